ball_motion_ctrl: RTL and testbench
===================================

Name: ball_motion_ctrl

Overview:
- Per-frame motion sequencer and bus arbiter for the ball sprite core.
- On each frame tick, integrates ball position and velocity (gravity, wall/floor bounce), then writes the new origin into the sprite core's x0/y0 registers over the core's slot bus.
- Shares that bus with MicroBlaze pass-through writes (sprite RAM, bypass) via a one-entry CPU hold buffer.
- Sits between the MMIO slot decoder and the sprite core.

Parameters:
- H_RES, 640, visible width in pixels.
- BALL_SIZE, 16, sprite edge length in pixels.
- FLOOR_Y, 400, maximum y0 (ball rests here).
- VW, 8, signed velocity width.
- VMAX, 15, velocity saturation magnitude.
- GRAVITY, 1, added to vy each frame.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse at vblank start.
- ctl_cs  in  1  controller register select.
- ctl_write  in  1  controller register write strobe.
- ctl_addr  in  3  controller register index.
- ctl_wr_data  in  32  controller write data.
- cpu_cs  in  1  CPU access to sprite core.
- cpu_write  in  1  CPU write strobe to sprite core.
- cpu_addr  in  14  CPU sprite-core address.
- cpu_wr_data  in  32  CPU sprite-core data.
- spr_cs  out  1  sprite core select.
- spr_write  out  1  sprite core write.
- spr_addr  out  14  sprite core address.
- spr_wr_data  out  32  sprite core data.
- pos_x  out  11  current x0.
- pos_y  out  11  current y0.
- bounce  out  1  one-cycle pulse on any wall/floor hit.
- overrun  out  1  sticky: frame_tick arrived while busy.

Behaviour:
- Reset values: pos_x=0, pos_y=0, vx=0, vy=0, enable=0, all spr_* outputs 0, bounce=0, overrun=0, hold buffer empty, FSM=IDLE.
- Controller registers, written when ctl_cs&ctl_write; effective next cycle:
  - 0: enable = data[0]; writing 1 also clears overrun.
  - 1: pos_x = data[10:0].
  - 2: pos_y = data[10:0].
  - 3: vx = data[VW-1:0].
  - 4: vy = data[VW-1:0].
  - 5: kick; vy = sat(vy + data[VW-1:0]).
  - 6-7: ignored.
- FSM: IDLE -> CALC -> WR_X -> WR_Y -> IDLE.
  - IDLE: on frame_tick & enable, go to CALC.
  - CALC, one cycle:
    - vy' = sat(vy+GRAVITY), saturated to ±VMAX.
    - nx = pos_x+vx; ny = pos_y+vy', both signed 13-bit.
    - nx<0: pos_x=0, vx=-vx, bounce.
    - nx>H_RES-BALL_SIZE: pos_x=H_RES-BALL_SIZE, vx=-vx, bounce.
    - ny<0: pos_y=0, vy=-vy', bounce.
    - ny>FLOOR_Y: pos_y=FLOOR_Y, vy=-(vy'-(vy'>>>2)) (arithmetic shift, 75% restitution), bounce.
    - Otherwise commit nx/ny/vy'. At most one bounce pulse per frame.
  - WR_X: drive spr_cs=1, spr_write=1, spr_addr=14'h2001, spr_wr_data={21'b0,pos_x} for exactly one cycle.
  - WR_Y: same with 14'h2002 and pos_y. Then IDLE.
- Latency: x0 write 2 cycles after frame_tick; y0 write 3 cycles after.
- Arbitration:
  - In WR_X/WR_Y the controller owns the bus. A CPU write arriving then is captured in the hold buffer and issued in the first cycle the FSM is not in WR_X/WR_Y.
  - The buffer holds one entry only. The CPU guarantees one write per ≥4 cycles, so no overflow handling is required.
  - With the buffer empty and FSM outside WR states, CPU writes pass combinationally to spr_*.
  - CPU writes to 14'h2001/14'h2002 are forwarded unchanged (debug override; overwritten next frame).
- Simultaneous events:
  - ctl write to pos/vel in the CALC cycle beats the computed value for that register only.
  - frame_tick while not IDLE is ignored and sets overrun.
  - enable=0 mid-sequence finishes the current WR_X/WR_Y, then halts.
- reset_n assertion mid-sequence aborts immediately to reset values; a pending hold-buffer entry is discarded.

Optional Feature:
- Macro: BALL_CTRL_FRICTION_EN.
- Defined: in CALC, when the resulting pos_y==FLOOR_Y, vx moves 1 toward 0 (no sign change past 0).
- Undefined: vx changes only on side-wall bounce.

Test Plan:
- Reset, then enable=1, pos=(100,100), vx=3, vy=0, one frame_tick -> spr write 14'h2001/103 at +2 cycles, 14'h2002/101 at +3 cycles, vy=1.
- pos_x=622, vx=5, tick -> pos_x=624, vx=-5, bounce pulse 1 cycle.
- pos_y=395, vy=10, tick -> vy'=11, pos_y=400, vy=-9 (-(11-2)); FRICTION_EN with vx=4 -> vx=3.
- CPU write 14'h0010/3 in the WR_X cycle -> appears on spr_* in the cycle after WR_Y; x0/y0 writes unaltered.
- frame_tick in WR_X -> ignored, overrun=1; ctl reg0 write 1 -> overrun=0.
- vy=15, tick -> vy stays 15 (saturation); kick -40 -> vy=-15.

Source files
------------

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl
//   Per-frame motion sequencer and slot-bus arbiter for the ball sprite core.
//   On every frame_tick while enabled:
//     - integrates velocity and position (gravity, wall/ceiling/floor bounce),
//     - writes the new origin to sprite core x0 (14'h2001), then y0 (14'h2002).
//   MicroBlaze pass-through writes share the sprite bus. A write that lands
//   while the sequencer owns the bus is parked in a one-entry hold buffer.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   frame_tick                one-cycle pulse at vblank start
//   ctl_cs/ctl_write/ctl_addr/ctl_wr_data   controller register writes
//   cpu_cs/cpu_write/cpu_addr/cpu_wr_data   CPU pass-through to sprite core
//   spr_cs/spr_write/spr_addr/spr_wr_data   sprite core slot bus
//   pos_x, pos_y              current sprite origin
//   bounce                    one-cycle pulse on any wall/floor hit
//   overrun                   sticky, frame_tick seen while busy
//
// Optional build macro
//   BALL_CTRL_FRICTION_EN : when the ball ends a frame on the floor, vx
//                           moves one step toward zero.

module ball_motion_ctrl #(
  parameter int H_RES     = 640,
  parameter int BALL_SIZE = 16,
  parameter int FLOOR_Y   = 400,
  parameter int VW        = 8,
  parameter int VMAX      = 15,
  parameter int GRAVITY   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        ctl_cs,
  input  logic        ctl_write,
  input  logic [2:0]  ctl_addr,
  input  logic [31:0] ctl_wr_data,
  input  logic        cpu_cs,
  input  logic        cpu_write,
  input  logic [13:0] cpu_addr,
  input  logic [31:0] cpu_wr_data,
  output logic        spr_cs,
  output logic        spr_write,
  output logic [13:0] spr_addr,
  output logic [31:0] spr_wr_data,
  output logic [10:0] pos_x,
  output logic [10:0] pos_y,
  output logic        bounce,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, CALC, WR_X, WR_Y} state_t;

  localparam logic signed [12:0] X_MAX = 13'(H_RES - BALL_SIZE);
  localparam logic signed [12:0] Y_MAX = 13'(FLOOR_Y);
  localparam logic signed [12:0] V_MAX = 13'(VMAX);

  state_t state, state_next;

  logic signed [VW-1:0] vx, vy;
  logic                 enable;

  logic        hold_valid;
  logic [13:0] hold_addr;
  logic [31:0] hold_data;

  logic ctl_we;
  logic bus_busy;
  logic unused_ctl;

  logic signed [12:0] vx_ext, vy_ext, kick_ext, vy_grav, vy_damp, kick_sum;
  logic signed [12:0] nx, ny;

  logic [10:0]          calc_px, calc_py;
  logic signed [VW-1:0] calc_vx, calc_vy;
  logic                 calc_hit;

  function automatic logic signed [12:0] sat_v(input logic signed [12:0] v);
    if (v > V_MAX)
      return V_MAX;
    else if (v < -V_MAX)
      return -V_MAX;
    else
      return v;
  endfunction

  assign ctl_we     = ctl_cs & ctl_write;
  assign bus_busy   = (state == WR_X) || (state == WR_Y);
  assign unused_ctl = ^ctl_wr_data[31:11];

  // Work in 13-bit signed so position + velocity never wraps before the
  // boundary comparisons.
  assign vx_ext   = {{(13-VW){vx[VW-1]}}, vx};
  assign vy_ext   = {{(13-VW){vy[VW-1]}}, vy};
  assign kick_ext = {{(13-VW){ctl_wr_data[VW-1]}}, ctl_wr_data[VW-1:0]};
  assign vy_grav  = sat_v(vy_ext + 13'(GRAVITY));
  assign kick_sum = sat_v(vy_ext + kick_ext);
  assign nx       = $signed({2'b00, pos_x}) + vx_ext;
  assign ny       = $signed({2'b00, pos_y}) + vy_grav;
  // Floor restitution keeps 75% of the speed: v - (v >>> 2).
  assign vy_damp  = vy_grav - (vy_grav >>> 2);

  // Candidate next-frame state; only committed in the CALC cycle.
  always_comb begin
    calc_px  = nx[10:0];
    calc_py  = ny[10:0];
    calc_vx  = vx;
    calc_vy  = VW'(vy_grav);
    calc_hit = 1'b0;

    if (nx < 0) begin
      calc_px  = '0;
      calc_vx  = -vx;
      calc_hit = 1'b1;
    end else if (nx > X_MAX) begin
      calc_px  = X_MAX[10:0];
      calc_vx  = -vx;
      calc_hit = 1'b1;
    end

    if (ny < 0) begin
      calc_py  = '0;
      calc_vy  = VW'(-vy_grav);
      calc_hit = 1'b1;
    end else if (ny > Y_MAX) begin
      calc_py  = Y_MAX[10:0];
      calc_vy  = VW'(-vy_damp);
      calc_hit = 1'b1;
    end

`ifdef BALL_CTRL_FRICTION_EN
    if (calc_py == Y_MAX[10:0]) begin
      if (calc_vx > 0)
        calc_vx = calc_vx - VW'(1);
      else if (calc_vx < 0)
        calc_vx = calc_vx + VW'(1);
    end
`endif
  end

  // Motion registers. Controller writes come after the CALC commit so a
  // same-cycle register write wins for that register only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_x   <= '0;
      pos_y   <= '0;
      vx      <= '0;
      vy      <= '0;
      enable  <= 1'b0;
      bounce  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      bounce <= 1'b0;
      if (state == CALC) begin
        pos_x  <= calc_px;
        pos_y  <= calc_py;
        vx     <= calc_vx;
        vy     <= calc_vy;
        bounce <= calc_hit;
      end

      if (ctl_we) begin
        case (ctl_addr)
          3'd0: enable <= ctl_wr_data[0];
          3'd1: pos_x  <= ctl_wr_data[10:0];
          3'd2: pos_y  <= ctl_wr_data[10:0];
          3'd3: vx     <= ctl_wr_data[VW-1:0];
          3'd4: vy     <= ctl_wr_data[VW-1:0];
          3'd5: vy     <= VW'(kick_sum);
          default: ;
        endcase
      end

      if (frame_tick && (state != IDLE))
        overrun <= 1'b1;
      else if (ctl_we && (ctl_addr == 3'd0) && ctl_wr_data[0])
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Dropping enable lets an in-flight x0 write finish but skips the rest.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_tick && enable) state_next = CALC;
      CALC:    state_next = WR_X;
      WR_X:    state_next = enable ? WR_Y : IDLE;
      WR_Y:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One-entry park for a CPU write that collides with the sequencer's writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
    end else if (bus_busy && cpu_cs && cpu_write && !hold_valid) begin
      hold_valid <= 1'b1;
      hold_addr  <= cpu_addr;
      hold_data  <= cpu_wr_data;
    end else if (!bus_busy && hold_valid) begin
      hold_valid <= 1'b0;
    end
  end

  always_comb begin
    spr_cs      = 1'b0;
    spr_write   = 1'b0;
    spr_addr    = '0;
    spr_wr_data = '0;
    if (state == WR_X) begin
      spr_cs      = 1'b1;
      spr_write   = 1'b1;
      spr_addr    = 14'h2001;
      spr_wr_data = {21'b0, pos_x};
    end else if (state == WR_Y) begin
      spr_cs      = 1'b1;
      spr_write   = 1'b1;
      spr_addr    = 14'h2002;
      spr_wr_data = {21'b0, pos_y};
    end else if (hold_valid) begin
      spr_cs      = 1'b1;
      spr_write   = 1'b1;
      spr_addr    = hold_addr;
      spr_wr_data = hold_data;
    end else if (cpu_cs) begin
      spr_cs      = 1'b1;
      spr_write   = cpu_write;
      spr_addr    = cpu_addr;
      spr_wr_data = cpu_wr_data;
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl
//   Scoreboard bench for ball_motion_ctrl. Every expected sprite-bus write
//   (address, data, cycle, bounce) is queued when stimulus is driven and
//   popped by a monitor when the DUT writes the bus.

module tb_ball_motion_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_tick;
  logic        ctl_cs, ctl_write;
  logic [2:0]  ctl_addr;
  logic [31:0] ctl_wr_data;
  logic        cpu_cs, cpu_write;
  logic [13:0] cpu_addr;
  logic [31:0] cpu_wr_data;
  logic        spr_cs, spr_write;
  logic [13:0] spr_addr;
  logic [31:0] spr_wr_data;
  logic [10:0] pos_x, pos_y;
  logic        bounce, overrun;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
    int          cyc;
    bit          chk_b;
    bit          exp_b;
  } wr_t;

  wr_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  m_px, m_py, m_vx, m_vy;

  ball_motion_ctrl dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .ctl_cs(ctl_cs), .ctl_write(ctl_write), .ctl_addr(ctl_addr), .ctl_wr_data(ctl_wr_data),
    .cpu_cs(cpu_cs), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
    .spr_cs(spr_cs), .spr_write(spr_write), .spr_addr(spr_addr), .spr_wr_data(spr_wr_data),
    .pos_x(pos_x), .pos_y(pos_y), .bounce(bounce), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int satv(input int v);
    if (v > 15) return 15;
    if (v < -15) return -15;
    return v;
  endfunction

  // Reference model of one frame; returns whether any bounce occurred.
  task automatic modelFrame(output bit hit);
    int vyp, nx, ny;
    hit = 1'b0;
    vyp = satv(m_vy + 1);
    nx  = m_px + m_vx;
    ny  = m_py + vyp;
    if (nx < 0) begin
      m_px = 0; m_vx = -m_vx; hit = 1'b1;
    end else if (nx > 624) begin
      m_px = 624; m_vx = -m_vx; hit = 1'b1;
    end else begin
      m_px = nx;
    end
    if (ny < 0) begin
      m_py = 0; m_vy = -vyp; hit = 1'b1;
    end else if (ny > 400) begin
      m_py = 400; m_vy = -(vyp - (vyp >>> 2)); hit = 1'b1;
    end else begin
      m_py = ny; m_vy = vyp;
    end
`ifdef BALL_CTRL_FRICTION_EN
    if (m_py == 400) begin
      if (m_vx > 0) m_vx = m_vx - 1;
      else if (m_vx < 0) m_vx = m_vx + 1;
    end
`endif
  endtask

  task automatic ctlWrite(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    ctl_cs = 1'b1; ctl_write = 1'b1; ctl_addr = a; ctl_wr_data = d;
    @(negedge clk); #1;
    ctl_cs = 1'b0; ctl_write = 1'b0; ctl_addr = '0; ctl_wr_data = '0;
  endtask

  task automatic applyStimulus(input int px, input int py, input int vx, input int vy);
    ctlWrite(3'd1, px);
    ctlWrite(3'd2, py);
    ctlWrite(3'd3, vx);
    ctlWrite(3'd4, vy);
    m_px = px; m_py = py; m_vx = vx; m_vy = vy;
  endtask

  // One frame; optionally a CPU write in WR_X, a second tick in WR_X, or a
  // controller pos_x write during CALC (ctl_px >= 0).
  task automatic runFrame(input bit with_cpu, input bit extra_tick, input int ctl_px);
    int  k;
    bit  hit;
    @(negedge clk); #1;
    frame_tick = 1'b1;
    k = cyc;
    modelFrame(hit);
    if (ctl_px >= 0) m_px = ctl_px;
    exp_q.push_back('{14'h2001, 32'(m_px), k + 2, 1'b1, hit});
    exp_q.push_back('{14'h2002, 32'(m_py), k + 3, 1'b1, 1'b0});
    if (with_cpu) exp_q.push_back('{14'h0010, 32'd3, k + 4, 1'b0, 1'b0});
    @(negedge clk); #1;
    frame_tick = 1'b0;
    if (ctl_px >= 0) begin
      ctl_cs = 1'b1; ctl_write = 1'b1; ctl_addr = 3'd1; ctl_wr_data = ctl_px;
    end
    @(negedge clk); #1;
    ctl_cs = 1'b0; ctl_write = 1'b0; ctl_addr = '0; ctl_wr_data = '0;
    if (with_cpu) begin
      cpu_cs = 1'b1; cpu_write = 1'b1; cpu_addr = 14'h0010; cpu_wr_data = 32'd3;
    end
    if (extra_tick) frame_tick = 1'b1;
    @(negedge clk); #1;
    cpu_cs = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pos_x", 32'(pos_x), 32'(m_px));
    checkOutput("pos_y", 32'(pos_y), 32'(m_py));
    checkOutput("queue_drained", exp_q.size(), 0);
  endtask

  task automatic cpuWrite(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    cpu_cs = 1'b1; cpu_write = 1'b1; cpu_addr = a; cpu_wr_data = d;
    exp_q.push_back('{a, d, cyc + 1, 1'b0, 1'b0});
    @(negedge clk); #1;
    cpu_cs = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
    repeat (2) @(negedge clk);
    checkOutput("cpu_drained", exp_q.size(), 0);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (reset_n && spr_cs && spr_write) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_spr_cs", 32'(spr_cs), 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("spr_addr", 32'(spr_addr), 32'(e.addr));
        checkOutput("spr_wr_data", spr_wr_data, e.data);
        checkOutput("wr_cycle", cyc, e.cyc);
        if (e.chk_b) checkOutput("bounce", 32'(bounce), 32'(e.exp_b));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_n = 1'b0; frame_tick = 1'b0;
    ctl_cs = 1'b0; ctl_write = 1'b0; ctl_addr = '0; ctl_wr_data = '0;
    cpu_cs = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
    m_px = 0; m_py = 0; m_vx = 0; m_vy = 0;

    repeat (3) @(negedge clk);
    checkOutput("rst_pos_x", 32'(pos_x), 0);
    checkOutput("rst_pos_y", 32'(pos_y), 0);
    checkOutput("rst_spr_cs", 32'(spr_cs), 0);
    checkOutput("rst_spr_addr", 32'(spr_addr), 0);
    checkOutput("rst_spr_data", spr_wr_data, 0);
    checkOutput("rst_bounce", 32'(bounce), 0);
    checkOutput("rst_overrun", 32'(overrun), 0);
    @(negedge clk); #1;
    reset_n = 1'b1;

    $display("[TB] tick while disabled");
    @(negedge clk); #1; frame_tick = 1'b1;
    @(negedge clk); #1; frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("disabled_pos_y", 32'(pos_y), 0);
    checkOutput("disabled_overrun", 32'(overrun), 0);

    $display("[TB] basic motion");
    ctlWrite(3'd0, 32'd1);
    applyStimulus(100, 100, 3, 0);
    runFrame(1'b0, 1'b0, -1);
    runFrame(1'b0, 1'b0, -1);

    $display("[TB] right wall");
    applyStimulus(622, 100, 5, 0);
    runFrame(1'b0, 1'b0, -1);
    runFrame(1'b0, 1'b0, -1);

    $display("[TB] floor bounce");
    applyStimulus(100, 395, 4, 10);
    runFrame(1'b0, 1'b0, -1);
    runFrame(1'b0, 1'b0, -1);

    $display("[TB] left wall and ceiling");
    applyStimulus(1, 5, -3, -10);
    runFrame(1'b0, 1'b0, -1);
    runFrame(1'b0, 1'b0, -1);

    $display("[TB] CPU write parked during WR_X");
    applyStimulus(200, 200, 1, 0);
    runFrame(1'b1, 1'b0, -1);

    $display("[TB] CPU pass-through");
    cpuWrite(14'h0123, 32'hDEAD_BEEF);
    cpuWrite(14'h2001, 32'd77);

    $display("[TB] overrun");
    applyStimulus(300, 100, 2, 0);
    runFrame(1'b0, 1'b1, -1);
    checkOutput("overrun_set", 32'(overrun), 1);
    ctlWrite(3'd0, 32'd1);
    checkOutput("overrun_clr", 32'(overrun), 0);

    $display("[TB] saturation and kick");
    applyStimulus(300, 100, 0, 15);
    runFrame(1'b0, 1'b0, -1);
    runFrame(1'b0, 1'b0, -1);
    ctlWrite(3'd5, 32'hFFFF_FFD8);
    m_vy = satv(m_vy - 40);
    runFrame(1'b0, 1'b0, -1);

    $display("[TB] controller write during CALC");
    applyStimulus(400, 100, 2, 0);
    runFrame(1'b0, 1'b0, 50);
    runFrame(1'b0, 1'b0, -1);

    repeat (4) @(negedge clk);
    checkOutput("final_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
